// File: rtl/gamma_loader.sv
// gamma_loader: turns an ioctl gamma download into gamma_bus table writes and gates
// the mixer's gamma enable. Define GAMMA_DEFAULT_RAMP_EN to fill an identity ramp after reset.
//
// state | meaning
// FILL  | writing the identity ramp, host stalled through ioctl_wait
// IDLE  | table stable, waiting for a gamma download
// LOAD  | forwarding download bytes as table writes

module gamma_loader #(
  parameter logic [7:0] INDEX   = 8'd2,
  parameter int         ENTRIES = 768
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  input  logic       gamma_enable,
  inout  wire [21:0] gamma_bus,
  output logic       busy,
  output logic       table_valid,
  output logic       load_err
);

  localparam logic [9:0] FULL = 10'(ENTRIES);

  typedef enum logic [1:0] {FILL, IDLE, LOAD} state_t;

`ifdef GAMMA_DEFAULT_RAMP_EN
  localparam state_t RST_STATE = FILL;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t     state, state_nx;
  logic [9:0] count, count_nx, count_acc;
  logic [9:0] addr_q, addr_nx;
  logic [7:0] value_q, value_nx;
  logic       wr_q, wr_nx;
  logic       en_q;
  logic       valid_nx, err_nx;
  logic       pend, pend_nx;
  logic       sel, sel_q, sel_rise, present;

  assign present  = gamma_bus[21];
  assign sel      = ioctl_download && (ioctl_index == INDEX);
  assign sel_rise = sel && !sel_q;

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    count_acc = count;
    addr_nx   = addr_q;
    value_nx  = value_q;
    wr_nx     = 1'b0;
    valid_nx  = table_valid;
    err_nx    = load_err;
    pend_nx   = pend;
    case (state)
      IDLE: begin
        pend_nx = 1'b0;
        if (present && sel && (sel_rise || pend)) begin
          state_nx = LOAD;
          count_nx = '0;
          valid_nx = 1'b0;
        end
      end
      LOAD: begin
        // a byte arriving with the sel fall still counts toward completeness
        if (ioctl_wr && (count < FULL)) begin
          wr_nx     = 1'b1;
          addr_nx   = count;
          value_nx  = ioctl_dout;
          count_acc = count + 10'd1;
        end
        count_nx = count_acc;
        if (!present) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          err_nx   = 1'b1;
        end else if (!sel) begin
          state_nx = IDLE;
          valid_nx = (count_acc == FULL);
          err_nx   = (count_acc != FULL);
        end
      end
`ifdef GAMMA_DEFAULT_RAMP_EN
      FILL: begin
        if (ioctl_wr) err_nx = 1'b1;
        if (sel_rise) pend_nx = 1'b1;
        if (!present) begin
          state_nx = IDLE;
        end else begin
          wr_nx    = 1'b1;
          addr_nx  = count;
          value_nx = count[7:0];
          if (count == FULL - 10'd1) begin
            state_nx = IDLE;
            valid_nx = 1'b1;
            count_nx = '0;
          end else begin
            count_nx = count + 10'd1;
          end
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= RST_STATE;
      count       <= '0;
      addr_q      <= '0;
      value_q     <= '0;
      wr_q        <= 1'b0;
      en_q        <= 1'b0;
      table_valid <= 1'b0;
      load_err    <= 1'b0;
      pend        <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      addr_q      <= addr_nx;
      value_q     <= value_nx;
      wr_q        <= wr_nx;
      en_q        <= gamma_enable && table_valid && (state == IDLE) && present;
      table_valid <= valid_nx;
      load_err    <= err_nx;
      pend        <= pend_nx;
      sel_q       <= sel;
    end
  end

`ifdef GAMMA_DEFAULT_RAMP_EN
  assign ioctl_wait = (state == FILL);
`else
  assign ioctl_wait = 1'b0;
`endif

  assign busy            = (state != IDLE);
  assign gamma_bus[20:0] = {clk_sys, en_q, wr_q, addr_q, value_q};

endmodule

// File: tb/tb_gamma_loader.sv
// Directed bench for gamma_loader: reset, full/short/long downloads, foreign index,
// missing presence and reset mid-load; follows GAMMA_DEFAULT_RAMP_EN for the ramp fill.

module tb_gamma_loader;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;
  logic [7:0] ioctl_dout;
  logic       ioctl_wait;
  logic       gamma_enable;
  logic       present;
  wire [21:0] gamma_bus;
  logic       busy;
  logic       table_valid;
  logic       load_err;

  assign gamma_bus[21] = present;

  gamma_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .gamma_enable   (gamma_enable),
    .gamma_bus      (gamma_bus),
    .busy           (busy),
    .table_valid    (table_valid),
    .load_err       (load_err)
  );

  always #5 clk_sys = ~clk_sys;

`ifdef GAMMA_DEFAULT_RAMP_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // write monitor: counts pulses and checks addr/value sequence against the stimulus
  int         wr_n, seq_err, first_wr_cyc, last_wr_cyc, drive_cyc;
  logic [9:0] last_addr;
  logic [7:0] last_val, exp_v;
  logic       busy_seen, mode_ramp, en_mid, valid_mid;

  always @(negedge clk_sys) begin
    if (busy) busy_seen = 1'b1;
    if (gamma_bus[18]) begin
      if (wr_n == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      last_addr   = gamma_bus[17:8];
      last_val    = gamma_bus[7:0];
      exp_v       = mode_ramp ? 8'(wr_n) : 8'(wr_n * 7 + 3);
      if (gamma_bus[17:8] != 10'(wr_n) || gamma_bus[7:0] != exp_v) seq_err++;
      wr_n++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_mon();
    wr_n = 0; seq_err = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    last_addr = '0; last_val = '0; busy_seen = 1'b0;
  endtask

  // entered and left at posedge+1
  task automatic download(input logic [7:0] idx, input int n, input bit end_with_wr);
    clear_mon();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < n; i++) begin
      if (i == 0) drive_cyc = cyc;
      ioctl_wr   = 1'b1;
      ioctl_dout = 8'(i * 7 + 3);
      if (end_with_wr && i == n - 1) ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      if (i == 10) begin
        en_mid    = gamma_bus[19];
        valid_mid = table_valid;
      end
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
  endtask

`ifdef GAMMA_DEFAULT_RAMP_EN
  task automatic wait_fill();
    int k;
    k = 0;
    while (busy && k < 2000) begin @(negedge clk_sys); k++; end
    check_eq("fill_done", busy, 0);
    check_eq("fill_wait_low", ioctl_wait, 0);
    check_eq("fill_valid", table_valid, 1);
    @(negedge clk_sys);
    check_eq("fill_en", gamma_bus[19], 1);
    @(posedge clk_sys); #1;
    check_eq("fill_wr_n", wr_n, 768);
    check_eq("fill_last_addr", last_addr, 767);
    check_eq("fill_last_val", last_val, 8'hFF);
    check_eq("fill_seq", seq_err, 0);
    check_eq("fill_span", last_wr_cyc - first_wr_cyc, 767);
    mode_ramp = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_dout = '0; present = 1'b1; gamma_enable = 1'b1; mode_ramp = 1'b1;
    en_mid = 1'b1; valid_mid = 1'b1; drive_cyc = 0;
    clear_mon();
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    @(negedge clk_sys);
    check_eq("rst_wr", gamma_bus[18], 0);
    check_eq("rst_en", gamma_bus[19], 0);
    check_eq("rst_addr", gamma_bus[17:8], 0);
    check_eq("rst_value", gamma_bus[7:0], 0);
    check_eq("rst_clk_bit", gamma_bus[20], 0);
    check_eq("rst_valid", table_valid, 0);
    check_eq("rst_err", load_err, 0);
    check_eq("rst_busy", busy, RST_BUSY);
    check_eq("rst_wait", ioctl_wait, RST_BUSY);
`ifdef GAMMA_DEFAULT_RAMP_EN
    wait_fill();
`endif
    mode_ramp = 1'b0;
    @(posedge clk_sys); #1;

    // full load, last byte together with the download fall
    download(8'd2, 768, 1'b1);
    check_eq("full_latency", first_wr_cyc - drive_cyc, 1);
    check_eq("full_wr_n", wr_n, 768);
    check_eq("full_last_addr", last_addr, 767);
    check_eq("full_seq", seq_err, 0);
    check_eq("full_valid", table_valid, 1);
    check_eq("full_err", load_err, 0);
    check_eq("full_busy", busy, 0);
    check_eq("full_en", gamma_bus[19], 1);

    download(8'd2, 768, 1'b0);
    check_eq("reload_en_mid", en_mid, 0);
    check_eq("reload_valid_mid", valid_mid, 0);
    check_eq("reload_valid", table_valid, 1);
    check_eq("reload_en", gamma_bus[19], 1);

    download(8'd2, 500, 1'b0);
    check_eq("short_wr_n", wr_n, 500);
    check_eq("short_seq", seq_err, 0);
    check_eq("short_err", load_err, 1);
    check_eq("short_valid", table_valid, 0);
    check_eq("short_en", gamma_bus[19], 0);

    download(8'd2, 768, 1'b0);
    check_eq("recover_err", load_err, 0);
    check_eq("recover_valid", table_valid, 1);

    download(8'd2, 800, 1'b0);
    check_eq("long_wr_n", wr_n, 768);
    check_eq("long_last_addr", last_addr, 767);
    check_eq("long_seq", seq_err, 0);
    check_eq("long_valid", table_valid, 1);
    check_eq("long_err", load_err, 0);

    download(8'd3, 100, 1'b0);
    check_eq("idx3_wr_n", wr_n, 0);
    check_eq("idx3_busy", busy_seen, 0);
    check_eq("idx3_valid", table_valid, 1);
    check_eq("idx3_err", load_err, 0);

    present = 1'b0;
    download(8'd2, 100, 1'b0);
    check_eq("nopres_wr_n", wr_n, 0);
    check_eq("nopres_busy", busy_seen, 0);
    check_eq("nopres_valid", table_valid, 1);
    present = 1'b1;
    @(posedge clk_sys); #1;

    // reset while byte 300 is being offered
    clear_mon();
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 300; i++) begin
      ioctl_wr = 1'b1; ioctl_dout = 8'(i * 7 + 3);
      @(posedge clk_sys); #1;
    end
    reset = 1'b1; ioctl_dout = 8'(300 * 7 + 3);
    @(posedge clk_sys); #1;
    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    @(negedge clk_sys);
    check_eq("abort_wr", gamma_bus[18], 0);
    check_eq("abort_valid", table_valid, 0);
    check_eq("abort_busy", busy, RST_BUSY);
    @(posedge clk_sys); #1;
    check_eq("abort_wr_n", wr_n, 300);
`ifdef GAMMA_DEFAULT_RAMP_EN
    clear_mon();
    mode_ramp = 1'b1;
    wait_fill();
`else
    repeat (3) begin @(posedge clk_sys); #1; end
    check_eq("abort_idle_wr_n", wr_n, 300);
    check_eq("abort_idle_valid", table_valid, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
